// File: rtl/ibuf_burst_initiator.sv
// Burst initiator for one instruction-buffer SRAM port: turns read/write descriptors
// into port beats, returning read data through a credit-protected FIFO.
module ibuf_burst_initiator #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 128,
  parameter int LEN_W      = 12,
  parameter int ADDR_MAX   = 24575,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_last,
  output logic                  done,
  output logic                  ib_cen,
  output logic                  ib_wen,
  output logic                  ib_last,
  output logic [ADDR_W-1:0]     ib_addr,
  output logic [DATA_W-1:0]     ib_wdata,
  output logic [DATA_W/8-1:0]   ib_wstrb,
  input  logic                  ib_ready,
  input  logic [DATA_W-1:0]     ib_rdata,
  input  logic                  ib_rvalid,
  input  logic                  ib_rlast,
  output logic                  ib_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD       = 2'd1,
    RD_DRAIN = 2'd2,
    WR       = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [ADDR_W-1:0]    addr_r;
  logic [LEN_W:0]       remaining_r;
  logic                 wen_r;
  logic                 done_r;
  logic [CNT_W-1:0]     outstanding_r;
  logic [CNT_W-1:0]     count_r;
  logic [PTR_W-1:0]     wptr_r, rptr_r;
  logic [DATA_W:0]      fifo_mem_r [FIFO_DEPTH];

  logic                 credit_ok_s, fire_s, rd_fire_s, last_beat_s;
  logic                 push_s, pop_s, head_last_s, cmd_take_s;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    next_addr = (a >= ADDR_W'(ADDR_MAX)) ? {ADDR_W{1'b0}} : a + ADDR_W'(1);
  endfunction

  // Credits cover both queued and in-flight beats so the FIFO can never overflow.
  assign credit_ok_s = ({1'b0, count_r} + {1'b0, outstanding_r}) < (CNT_W+1)'(FIFO_DEPTH);
  assign ib_cen      = ((state_r == RD) && credit_ok_s) || ((state_r == WR) && wr_valid);
  assign fire_s      = ib_cen && ib_ready;
  assign rd_fire_s   = fire_s && (state_r == RD);
  assign last_beat_s = (remaining_r == (LEN_W+1)'(1));
  assign ib_last     = ib_cen && last_beat_s;
  assign ib_addr     = addr_r;
  assign ib_wen      = wen_r;
  assign rd_valid    = (count_r != {CNT_W{1'b0}});
  assign rd_data     = fifo_mem_r[rptr_r][DATA_W:1];
  assign head_last_s = fifo_mem_r[rptr_r][0];
  assign rd_last     = rd_valid && head_last_s;
  assign pop_s       = rd_valid && rd_ready;
  assign push_s      = ib_rvalid && ib_rready && ((count_r != CNT_W'(FIFO_DEPTH)) || pop_s);
  assign cmd_take_s  = cmd_ready && cmd_valid;
  assign done        = done_r || ((state_r == WR) && fire_s && last_beat_s);

  // Next-state and per-state port controls.
  always_comb begin
    state_s   = state_r;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    ib_rready = 1'b0;
    ib_wdata  = {DATA_W{1'b0}};
    ib_wstrb  = {STRB_W{1'b0}};
    case (state_r)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_s = cmd_wr ? WR : RD;
        else           state_s = IDLE;
      end
      RD: begin
        ib_rready = 1'b1;
        if (fire_s && last_beat_s) state_s = RD_DRAIN;
        else                       state_s = RD;
      end
      RD_DRAIN: begin
        ib_rready = 1'b1;
        if (pop_s && head_last_s) state_s = IDLE;
        else                      state_s = RD_DRAIN;
      end
      WR: begin
        wr_ready = ib_ready;
        ib_wdata = wr_data;
        ib_wstrb = wr_strb;
        if (fire_s && last_beat_s) state_s = IDLE;
        else                       state_s = WR;
      end
      default: state_s = IDLE;
    endcase
  end

  // Control state, burst address/length and outstanding-read tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      addr_r        <= {ADDR_W{1'b0}};
      remaining_r   <= {(LEN_W+1){1'b0}};
      wen_r         <= 1'b0;
      done_r        <= 1'b0;
      outstanding_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      done_r  <= (state_r == RD_DRAIN) && pop_s && head_last_s;
      if (cmd_take_s) begin
        addr_r      <= cmd_addr;
        remaining_r <= {1'b0, cmd_len} + (LEN_W+1)'(1);
        wen_r       <= cmd_wr;
      end else if (fire_s) begin
        addr_r      <= next_addr(addr_r);
        remaining_r <= remaining_r - (LEN_W+1)'(1);
      end else begin
        addr_r      <= addr_r;
        remaining_r <= remaining_r;
      end
      case ({rd_fire_s, push_s})
        2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
        2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // Return FIFO; pop frees the head before a same-cycle push lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= {(DATA_W+1){1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wptr_r] <= {ib_rdata, ib_rlast};
        wptr_r             <= wptr_r + PTR_W'(1);
      end
      if (pop_s) rptr_r <= rptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_ibuf_burst_initiator.sv
// Bench for ibuf_burst_initiator: SRAM responder model, request/response scoreboards,
// a descriptor table plus hand sequences for stall, reset and strobe corner cases.
module tb_ibuf_burst_initiator;
  localparam int AW = 15, DW = 128, LW = 12, SW = 16, AMAX = 24575;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic wr_valid = 1'b0, wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic [SW-1:0] wr_strb = '0;
  logic rd_valid, rd_ready = 1'b1, rd_last, done;
  logic [DW-1:0] rd_data;
  logic ib_cen, ib_wen, ib_last, ib_ready = 1'b1, ib_rvalid = 1'b0, ib_rlast = 1'b0, ib_rready;
  logic [AW-1:0] ib_addr;
  logic [DW-1:0] ib_wdata, ib_rdata = '0;
  logic [SW-1:0] ib_wstrb;

  ibuf_burst_initiator dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_strb(wr_strb), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last), .done(done), .ib_cen(ib_cen), .ib_wen(ib_wen),
    .ib_last(ib_last), .ib_addr(ib_addr), .ib_wdata(ib_wdata), .ib_wstrb(ib_wstrb),
    .ib_ready(ib_ready), .ib_rdata(ib_rdata), .ib_rvalid(ib_rvalid), .ib_rlast(ib_rlast),
    .ib_rready(ib_rready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic last; } req_t;
  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct { logic [AW-1:0] addr; logic last; int due; } resp_t;
  typedef struct { logic wr; logic [AW-1:0] addr; int len; int rr; int lat; int exp_beats; logic [AW-1:0] exp_last; } vec_t;

  logic [DW-1:0] mem [0:32767];
  req_t  exp_req_q[$];
  beat_t exp_rd_q[$];
  resp_t resp_q[$];
  logic [DW-1:0] wd_q[$];
  logic [SW-1:0] ws_q[$];

  int total = 0, bad = 0, cyc = 0, lat = 1, rr_mode = 0;
  int fires = 0, pops = 0, done_cnt = 0, done_cyc = -1, last_fire_cyc = -1, last_pop_cyc = -1;
  int tb_out = 0, tb_fifo = 0, occ_max = 0, stall_beat = -1, stall_n = 0;
  logic [AW-1:0] last_fire_addr = '0;
  logic prev_stall = 1'b0;
  logic [162:0] prev_req = '0;
  req_t mon_r;
  beat_t mon_b;
  resp_t rsp;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    logic [31:0] v;
    v = a;
    return {v * 32'h9E3779B1, ~v, v ^ 32'h5A5A5A5A, v + 32'h01000000};
  endfunction

  function automatic logic [DW-1:0] strb_mask(input logic [SW-1:0] s);
    logic [DW-1:0] m;
    for (int b = 0; b < SW; b++) m[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // Monitor: request scoreboard, write memory update, return accounting, rd scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0; tb_out = 0; tb_fifo = 0;
    end else begin
      if (prev_stall) chk("stall_hold", {ib_cen, ib_wen, ib_last, ib_addr, ib_wdata, ib_wstrb}, prev_req);
      prev_stall = ib_cen && !ib_ready;
      prev_req = {ib_cen, ib_wen, ib_last, ib_addr, ib_wdata, ib_wstrb};
      if (ib_cen && ib_ready) begin
        fires++; last_fire_cyc = cyc; last_fire_addr = ib_addr;
        if (exp_req_q.size() == 0) chk("unexpected_req", ib_addr, 15'h7fff);
        else begin
          mon_r = exp_req_q.pop_front();
          chk("ib_addr", ib_addr, mon_r.addr);
          chk("ib_last", ib_last, mon_r.last);
        end
        if (ib_wen) begin
          for (int b = 0; b < SW; b++) if (ib_wstrb[b]) mem[ib_addr][8*b +: 8] = ib_wdata[8*b +: 8];
        end else begin
          resp_q.push_back('{ib_addr, ib_last, cyc + lat});
          tb_out++;
        end
      end
      if (ib_rvalid && ib_rready) begin tb_out--; tb_fifo++; end
      if (rd_valid && rd_ready) begin
        pops++; tb_fifo--;
        if (exp_rd_q.size() == 0) chk("unexpected_rd", rd_data, '0);
        else begin
          mon_b = exp_rd_q.pop_front();
          chk("rd_data", rd_data, mon_b.data);
          chk("rd_last", rd_last, mon_b.last);
          if (rd_last) last_pop_cyc = cyc;
        end
      end
      if (tb_out + tb_fifo > occ_max) occ_max = tb_out + tb_fifo;
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  // Responder with fixed latency, plus rd_ready throttling.
  always @(posedge clk) begin
    #1;
    ib_rvalid = 1'b0; ib_rlast = 1'b0; ib_rdata = '0;
    if (resp_q.size() > 0 && resp_q[0].due <= cyc + 1) begin
      rsp = resp_q.pop_front();
      ib_rvalid = 1'b1; ib_rlast = rsp.last; ib_rdata = mem[rsp.addr];
    end
    rd_ready = (rr_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr, input int len);
    logic [AW-1:0] a;
    int g;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      exp_req_q.push_back('{a, (i == len)});
      if (!wr) exp_rd_q.push_back('{mem[a], (i == len)});
      a = (a >= AW'(AMAX)) ? '0 : a + 15'd1;
    end
    g = 0; tick();
    while (!cmd_ready && g < 200) begin tick(); g++; end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = LW'(len);
    tick();
    chk("cmd_accept", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_burst(input logic wr, input logic [AW-1:0] addr, input int len, output int beats);
    int sf, sp, sd, g;
    sf = fires; sp = pops; sd = done_cnt;
    issue_cmd(wr, addr, len);
    if (wr) begin
      for (int i = 0; i <= len; i++) begin
        wr_valid = 1'b1;
        wr_data = (wd_q.size() > 0) ? wd_q.pop_front() : {$urandom, $urandom, $urandom, $urandom};
        wr_strb = (ws_q.size() > 0) ? ws_q.pop_front() : 16'hFFFF;
        if (i == stall_beat) begin
          ib_ready = 1'b0;
          repeat (stall_n) begin tick(); @(posedge clk); #1; end
          ib_ready = 1'b1;
        end
        g = 0; tick();
        if (i == 0) chk("cmd_ready_busy", cmd_ready, 1'b0);
        while (!wr_ready && g < 50) begin @(posedge clk); #1; tick(); g++; end
        if (g >= 50) chk("wr_accept_timeout", wr_ready, 1'b1);
        @(posedge clk); #1;
      end
      wr_valid = 1'b0;
    end else begin
      tick();
      chk("cmd_ready_busy", cmd_ready, 1'b0);
    end
    g = 0;
    while (done_cnt == sd && g < 400) begin tick(); g++; end
    if (wr) chk("done_at_last_fire", done_cyc, last_fire_cyc);
    else begin
      chk("done_after_last_pop", done_cyc, last_pop_cyc + 1);
      chk("rd_pops", pops - sp, len + 1);
    end
    tick(); tick();
    chk("done_once", done_cnt - sd, 1);
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    chk("req_q_empty", exp_req_q.size(), 0);
    chk("rd_q_empty", exp_rd_q.size(), 0);
    beats = fires - sf;
  endtask

  vec_t tbl[9];
  logic [DW-1:0] d3[3], expm[3];
  logic [SW-1:0] s3[3];
  int n, g, sd;
  logic any_rv;

  initial begin
    for (int a = 0; a < 32768; a++) mem[a] = pat(a);
    tbl[0] = '{1'b0, 15'h0010, 3, 0, 1, 4, 15'h0013};
    tbl[1] = '{1'b0, 15'h0100, 7, 1, 1, 8, 15'h0107};
    tbl[2] = '{1'b0, 15'd24574, 3, 0, 1, 4, 15'd1};
    tbl[3] = '{1'b0, 15'h0020, 0, 0, 1, 1, 15'h0020};
    tbl[4] = '{1'b1, 15'h0300, 0, 0, 1, 1, 15'h0300};
    tbl[5] = '{1'b0, 15'h0040, 5, 0, 3, 6, 15'h0045};
    tbl[6] = '{1'b1, 15'h0500, 3, 0, 1, 4, 15'h0503};
    tbl[7] = '{1'b0, 15'd30000, 1, 1, 2, 2, 15'd0};
    tbl[8] = '{1'b0, 15'h0500, 3, 0, 2, 4, 15'h0503};

    tick(); tick();
    chk("reset_ctrl", {cmd_ready, rd_valid, rd_last, done, ib_cen, ib_wen, ib_last, wr_ready, ib_rready, ib_addr, ib_wstrb}, {1'b1, 39'b0});
    @(posedge clk); #1; rst_n = 1'b1;
    tick();
    chk("post_reset_data", {rd_data, ib_wdata}, '0);

    for (int i = 0; i < 9; i++) begin
      rr_mode = tbl[i].rr; lat = tbl[i].lat;
      run_burst(tbl[i].wr, tbl[i].addr, tbl[i].len, n);
      chk("beats", n, tbl[i].exp_beats);
      chk("last_addr", last_fire_addr, tbl[i].exp_last);
    end
    rr_mode = 0; lat = 1;

    // Strobed write with a two-cycle arbitration stall on beat 2, then read back.
    s3[0] = 16'hFFFF; s3[1] = 16'h00FF; s3[2] = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      d3[i] = {$urandom, $urandom, $urandom, $urandom};
      expm[i] = (pat(32'h2000 + i) & ~strb_mask(s3[i])) | (d3[i] & strb_mask(s3[i]));
      wd_q.push_back(d3[i]); ws_q.push_back(s3[i]);
    end
    stall_beat = 1; stall_n = 2;
    run_burst(1'b1, 15'h2000, 2, n);
    stall_beat = -1;
    chk("wr_beats", n, 3);
    chk("wr_last_addr", last_fire_addr, 15'h2002);
    @(posedge clk); #1; wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("extra_wr_blocked", {wr_ready, ib_cen}, 2'b00);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) chk("wr_merge", mem[15'h2000 + i], expm[i]);
    run_burst(1'b0, 15'h2000, 2, n);
    chk("rb_beats", n, 3);

    // Reset with two reads in flight; late responses must be dropped.
    lat = 4; sd = done_cnt;
    issue_cmd(1'b0, 15'h0600, 7);
    g = 0;
    while (tb_out < 2 && g < 50) begin tick(); g++; end
    chk("two_outstanding", tb_out, 2);
    @(posedge clk); #1; rst_n = 1'b0;
    tick();
    chk("in_reset_ctrl", {cmd_ready, rd_valid, done, ib_cen, ib_last, wr_ready, ib_rready}, 7'b1000000);
    @(posedge clk); #1; rst_n = 1'b1;
    exp_req_q.delete(); exp_rd_q.delete();
    tick();
    chk("after_reset_ctrl", {cmd_ready, rd_valid, rd_last, done, ib_cen, ib_wen, ib_last, wr_ready, ib_rready, ib_addr, ib_wstrb}, {1'b1, 39'b0});
    chk("after_reset_data", {rd_data, ib_wdata}, '0);
    any_rv = 1'b0;
    repeat (8) begin tick(); any_rv = any_rv | rd_valid; end
    chk("late_resp_dropped", any_rv, 1'b0);
    chk("no_done_on_reset", done_cnt - sd, 0);
    lat = 1;
    run_burst(1'b0, 15'h0700, 0, n);
    chk("post_reset_read", n, 1);
    chk("post_reset_last", last_fire_addr, 15'h0700);

    chk("credit_occ_ok", (occ_max <= 4), 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
